// File: rtl/mem_seq_pkg.sv
// Shared constants and helpers for the data-memory access sequencer.
package mem_seq_pkg;

  // Sequencer states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bit positions inside the one-hot l_choose load-type vector
  localparam int unsigned LC_LD  = 0;
  localparam int unsigned LC_LW  = 1;
  localparam int unsigned LC_LWU = 2;
  localparam int unsigned LC_LH  = 3;
  localparam int unsigned LC_LHU = 4;
  localparam int unsigned LC_LB  = 5;
  localparam int unsigned LC_LBU = 6;

  // Access size in bytes; loads decode l_choose, stores decode wmask.
  // Unrecognised encodings fall back to a single byte.
  function automatic logic [3:0] access_size(input logic       is_load,
                                             input logic [6:0] l_choose,
                                             input logic [7:0] wmask);
    logic [3:0] sz;
    sz = 4'd1;
    if (is_load) begin
      if (l_choose[LC_LD]) begin
        sz = 4'd8;
      end else if (l_choose[LC_LW] || l_choose[LC_LWU]) begin
        sz = 4'd4;
      end else if (l_choose[LC_LH] || l_choose[LC_LHU]) begin
        sz = 4'd2;
      end else begin
        sz = 4'd1;
      end
    end else begin
      case (wmask)
        8'h03:   sz = 4'd2;
        8'h0F:   sz = 4'd4;
        8'hFF:   sz = 4'd8;
        default: sz = 4'd1;
      endcase
    end
    return sz;
  endfunction

  // Right-justified byte mask for a given access size
  function automatic logic [7:0] size_mask(input logic [3:0] sz);
    logic [7:0] m;
    case (sz)
      4'd1:    m = 8'h01;
      4'd2:    m = 8'h03;
      4'd4:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane alignment: store shift/strobe, load shift/extend.
module mem_lane_align
  import mem_seq_pkg::*;
(
  input  logic [2:0]  off,
  input  logic [63:0] wdata,
  input  logic [7:0]  wmask,
  input  logic [6:0]  l_choose,
  input  logic [63:0] rdata,
  output logic [63:0] bus_wdata,
  output logic [7:0]  bus_wstrb,
  output logic [63:0] ld_ext
);

  logic [63:0] shifted;

  assign bus_wdata = wdata << {off, 3'b000};
  assign bus_wstrb = wmask << off;
  assign shifted   = rdata >> {off, 3'b000};

  // Select the loaded field and sign/zero-extend it to 64 bits
  always_comb begin
    ld_ext = shifted;
    if (l_choose[LC_LD]) begin
      ld_ext = shifted;
    end else if (l_choose[LC_LW]) begin
      ld_ext = {{32{shifted[31]}}, shifted[31:0]};
    end else if (l_choose[LC_LWU]) begin
      ld_ext = {32'b0, shifted[31:0]};
    end else if (l_choose[LC_LH]) begin
      ld_ext = {{48{shifted[15]}}, shifted[15:0]};
    end else if (l_choose[LC_LHU]) begin
      ld_ext = {48'b0, shifted[15:0]};
    end else if (l_choose[LC_LB]) begin
      ld_ext = {{56{shifted[7]}}, shifted[7:0]};
    end else if (l_choose[LC_LBU]) begin
      ld_ext = {56'b0, shifted[7:0]};
    end
  end

endmodule

// File: rtl/mem_access_seq.sv
// Multi-cycle load/store sequencer between decode/control and a req/ack data bus.
module mem_access_seq
  import mem_seq_pkg::*;
#(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_valid,
  input  logic              data_ram_en,
  input  logic              data_ram_wen,
  input  logic [7:0]        wmask,
  input  logic [6:0]        l_choose,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wstrb,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_finish,
  output logic [DATA_W-1:0] ld_data,
  output logic              busy,
  output logic              misalign,
  output logic              bus_err
);

  logic [1:0]        state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [7:0]        wmask_q;
  logic [6:0]        lch_q;
  logic              we_q;
  logic              misalign_q;
  logic              bus_err_q;
  logic [DATA_W-1:0] ld_data_q;

  logic              is_mem;
  logic [3:0]        access_sz;
  logic [2:0]        align_mask;
  logic              misal;
  logic              start;
  logic              timeout;
  logic [DATA_W-1:0] bus_wdata;
  logic [7:0]        bus_wstrb;
  logic [DATA_W-1:0] ld_ext;

  assign is_mem     = data_ram_en | data_ram_wen;
  assign access_sz  = access_size(data_ram_en, l_choose, wmask);
  assign align_mask = 3'(access_sz - 4'd1);
  assign misal      = |(addr[2:0] & align_mask);
  assign start      = (state_q == ST_IDLE) && inst_valid && is_mem;
  // An ack in the final wait cycle takes priority over the timeout
  assign timeout    = (state_q == ST_REQ) && !mem_ack && (cnt_q == 16'(TIMEOUT - 1));

  mem_lane_align u_lane (
    .off       (addr_q[2:0]),
    .wdata     (wdata_q),
    .wmask     (wmask_q),
    .l_choose  (lch_q),
    .rdata     (mem_rdata),
    .bus_wdata (bus_wdata),
    .bus_wstrb (bus_wstrb),
    .ld_ext    (ld_ext)
  );

  // Next-state and wait-counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = misal ? ST_DONE : ST_REQ;
          cnt_d   = '0;
        end
      end
      ST_REQ: begin
        if (mem_ack || timeout) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter and latched transaction registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      lch_q      <= '0;
      we_q       <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      ld_data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (start) begin
        addr_q     <= addr;
        wdata_q    <= wdata;
        // Canonical mask from the decoded size keeps the strobe non-zero
        wmask_q    <= size_mask(access_sz);
        lch_q      <= l_choose;
        we_q       <= data_ram_wen & ~data_ram_en;
        misalign_q <= misal;
        bus_err_q  <= 1'b0;
      end
      if (state_q == ST_REQ) begin
        if (mem_ack) begin
          if (!we_q) ld_data_q <= ld_ext;
        end else if (timeout) begin
          bus_err_q <= 1'b1;
          if (!we_q) ld_data_q <= '0;
        end
      end
    end
  end

  // Bus and status outputs; bus fields are only driven while requesting
  always_comb begin
    mem_req    = (state_q == ST_REQ);
    mem_we     = mem_req & we_q;
    mem_addr   = mem_req ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
    mem_wdata  = mem_req ? bus_wdata : '0;
    mem_wstrb  = mem_req ? bus_wstrb : '0;
    busy       = (state_q != ST_IDLE);
    misalign   = (state_q == ST_DONE) & misalign_q;
    bus_err    = (state_q == ST_DONE) & bus_err_q;
    ld_data    = ld_data_q;
    mem_finish = !rst && (((state_q == ST_IDLE) && inst_valid && !is_mem) ||
                          (state_q == ST_DONE));
  end

endmodule

// File: tb/tb_mem_access_seq.sv
// Self-checking bench for mem_access_seq: directed cases plus randomized accesses.
module tb_mem_access_seq;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid;
  logic        data_ram_en;
  logic        data_ram_wen;
  logic [7:0]  wmask;
  logic [6:0]  l_choose;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        mem_finish;
  logic [63:0] ld_data;
  logic        busy;
  logic        misalign;
  logic        bus_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] ld_model = 64'd0;

  // Load type table indexed like l_choose bits: ld lw lwu lh lhu lb lbu
  int lsize [7] = '{8, 4, 4, 2, 2, 1, 1};
  bit lsign [7] = '{0, 1, 0, 1, 0, 1, 0};

  mem_access_seq #(
    .ADDR_W  (64),
    .DATA_W  (64),
    .TIMEOUT (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_valid   (inst_valid),
    .data_ram_en  (data_ram_en),
    .data_ram_wen (data_ram_wen),
    .wmask        (wmask),
    .l_choose     (l_choose),
    .addr         (addr),
    .wdata        (wdata),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .mem_finish   (mem_finish),
    .ld_data      (ld_data),
    .busy         (busy),
    .misalign     (misalign),
    .bus_err      (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected load result: pick size bytes at the byte offset, then extend
  function automatic logic [63:0] ext_model(input logic [63:0] rd, input int off,
                                            input int sz, input bit sgn);
    logic [63:0] v;
    logic [63:0] m;
    v = rd >> (8 * off);
    m = (sz == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * sz)) - 64'd1);
    v = v & m;
    if (sgn && v[8 * sz - 1]) v = v | ~m;
    return v;
  endfunction

  // One instruction: kind 0 = no memory op, 1 = load, 2 = store, 3 = both set.
  // wt = number of wait cycles before ack (>= TMO means no ack at all).
  task automatic do_op(input int kind, input int lt, input int ssz, input logic [63:0] a,
                       input logic [63:0] wd, input logic [63:0] rd, input int wt);
    bit          is_ld;
    int          sz;
    int          off;
    bit          mis;
    bit          acked;
    logic [7:0]  wm;
    logic [7:0]  exp_strb;
    wm = 8'((1 << ssz) - 1);
    @(posedge clk); #1;
    inst_valid   = 1'b1;
    data_ram_en  = (kind == 1 || kind == 3);
    data_ram_wen = (kind == 2 || kind == 3);
    l_choose     = 7'(1 << lt);
    wmask        = wm;
    addr         = a;
    wdata        = wd;
    mem_rdata    = rd;
    mem_ack      = 1'b0;
    if (kind == 0) begin
      @(negedge clk);
      check("nop_finish", 64'(mem_finish), 64'd1);
      check("nop_busy", 64'(busy), 64'd0);
      check("nop_req", 64'(mem_req), 64'd0);
      @(posedge clk); #1;
      inst_valid = 1'b0;
      @(negedge clk);
      check("nop_after", {62'd0, busy, mem_finish}, 64'd0);
      return;
    end
    is_ld = (kind != 2);
    sz    = is_ld ? lsize[lt] : ssz;
    off   = int'(a[2:0]);
    mis   = (a % 64'(sz)) != 64'd0;
    @(negedge clk);
    check("start_idle", {62'd0, mem_req, mem_finish}, 64'd0);
    @(posedge clk); #1;
    if (mis) begin
      inst_valid = 1'b0;
      mem_ack    = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("mis_req", 64'(mem_req), 64'd0);
      check("mis_flags", {60'd0, mem_finish, misalign, bus_err, busy}, 64'b1101);
      check("mis_ld", ld_data, ld_model);
    end else begin
      acked    = 1'b0;
      exp_strb = 8'(((1 << sz) - 1) << off);
      for (int k = 0; k < TMO; k++) begin
        mem_ack = (k == wt);
        @(negedge clk);
        check("req_hi", {62'd0, mem_req, busy}, 64'b11);
        check("req_we", 64'(mem_we), 64'(!is_ld));
        check("req_addr", mem_addr, {a[63:3], 3'b000});
        check("req_wstrb", 64'(mem_wstrb), 64'(exp_strb));
        if (!is_ld) check("req_wdata", mem_wdata, wd << (8 * off));
        check("req_nofin", 64'(mem_finish), 64'd0);
        if (k == wt) begin
          acked = 1'b1;
          break;
        end
        if (k != TMO - 1) begin
          @(posedge clk); #1;
        end
      end
      @(posedge clk); #1;
      inst_valid = 1'b0;
      mem_ack    = 1'($urandom_range(0, 1));
      if (is_ld) ld_model = acked ? ext_model(rd, off, sz, lsign[lt]) : 64'd0;
      @(negedge clk);
      check("done_req", 64'(mem_req), 64'd0);
      check("done_flags", {61'd0, mem_finish, misalign, bus_err}, {61'd0, 1'b1, 1'b0, !acked});
      check("done_ld", ld_data, ld_model);
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    check("back_idle", {62'd0, busy, mem_finish}, 64'd0);
  endtask

  initial begin
    int          kind;
    int          lt;
    int          ssz;
    int          wt;
    logic [63:0] a;
    rst          = 1'b1;
    inst_valid   = 1'b0;
    data_ram_en  = 1'b0;
    data_ram_wen = 1'b0;
    wmask        = 8'h00;
    l_choose     = 7'h00;
    addr         = 64'd0;
    wdata        = 64'd0;
    mem_ack      = 1'b0;
    mem_rdata    = 64'd0;

    @(negedge clk);
    check("rst_ctrl", {58'd0, mem_req, mem_we, mem_finish, busy, misalign, bus_err}, 64'd0);
    check("rst_bus", mem_addr | mem_wdata | 64'(mem_wstrb), 64'd0);
    check("rst_ld", ld_data, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // lw 0x1004, zero-wait
    do_op(1, 1, 1, 64'h1004, 64'd0, 64'h8000_0001_0000_0000, 0);
    check("lw_value", ld_data, 64'hFFFF_FFFF_8000_0001);
    // sb 0x2003, three wait cycles
    do_op(2, 0, 1, 64'h2003, 64'hAB, 64'hDEAD_BEEF_DEAD_BEEF, 3);
    check("sb_ld_kept", ld_data, 64'hFFFF_FFFF_8000_0001);
    // lhu 0x3001 misaligned
    do_op(1, 4, 1, 64'h3001, 64'd0, 64'h1234, 0);
    // ld with no ack -> bus error
    do_op(1, 0, 1, 64'h4000, 64'd0, 64'h5555, 99);
    check("ld_tmo_zero", ld_data, 64'd0);
    // addi
    do_op(0, 0, 1, 64'h0, 64'd0, 64'd0, 0);

    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 9) < 1 ? 0 : ($urandom_range(0, 9) < 1 ? 3 : $urandom_range(1, 2));
      lt   = $urandom_range(0, 6);
      ssz  = 1 << $urandom_range(0, 3);
      a    = {$urandom, $urandom};
      if ($urandom_range(0, 9) < 7) begin
        a = a & ~64'((kind == 2 ? ssz : lsize[lt]) - 1);
      end
      wt = $urandom_range(0, TMO + 1);
      do_op(kind, lt, ssz, a, {$urandom, $urandom}, {$urandom, $urandom}, wt);
    end

    // Reset while a ld is waiting in REQ
    @(posedge clk); #1;
    inst_valid  = 1'b1;
    data_ram_en = 1'b1;
    data_ram_wen = 1'b0;
    l_choose    = 7'h01;
    addr        = 64'h5000;
    @(posedge clk); #1;
    check("pre_rst_req", 64'(mem_req), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid", {61'd0, mem_req, mem_finish, busy}, 64'd0);
    inst_valid  = 1'b0;
    data_ram_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst", {61'd0, mem_req, mem_finish, busy}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
